program_memory_loader: RTL and testbench
========================================

Name: program_memory_loader

Overview:
- Instruction-side memory responder for the CPU fetch port.
- Serves 32-bit instruction words on `instructionAddr`/`selInstruction`.
- Contains a byte-stream loader that writes a program image into the store while holding the CPU disabled, then releases it with a one-cycle reset pulse.
- Sits between the board's byte source (UART receiver or test bench) and the CPU's ROM pins.

Parameters:
- ADDR_W, 12, instruction address width; store depth = 2^ADDR_W words.
- NOP_WORD, 32'h0000000F, word driven when fetch is not served (decodes to the CPU NOP group).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- res  input  1  reset; synchronous, active-high.
- instructionAddr  input  ADDR_W  fetch address from CPU.
- selInstruction  input  1  fetch select from CPU.
- instruction  output  32  fetched word.
- loadStart  input  1  single-cycle request to begin a program load.
- byteValid  input  1  byte source has a byte on byteData.
- byteData  input  8  incoming byte.
- byteReady  output  1  loader accepts a byte this cycle; transfer occurs when byteValid & byteReady.
- loading  output  1  high from loadStart acceptance until release completes.
- cpuEnable  output  1  drives CPU enable.
- cpuRes  output  1  drives CPU res; one-cycle pulse after load.
- loadDone  output  1  one-cycle pulse concurrent with cpuRes.

Behaviour:
Reset (res=1 at a rising edge):
- state=IDLE; byteReady=0, loading=0, cpuRes=0, loadDone=0, cpuEnable=0.
- Internal loaded flag cleared; all counters cleared.
- Store contents are NOT cleared.
- Reset mid-load aborts the load. Words already written remain; the CPU stays disabled until a complete load.

Fetch path (combinational):
- instruction = mem[instructionAddr] when selInstruction=1 and state=IDLE and loaded=1.
- Otherwise instruction = NOP_WORD.

States:
- IDLE:
  - byteReady=0.
  - cpuEnable=loaded.
  - loadStart=1 → LEN_LO; cpuEnable drops to 0 the same edge; loading=1.
- LEN_LO:
  - byteReady=1.
  - On transfer, len[7:0]=byte → LEN_HI.
- LEN_HI:
  - byteReady=1.
  - On transfer, len[11:8]=byte[3:0]; byte[7:4] ignored.
  - If the resulting 12-bit len=0 → RELEASE; else → DATA with wordAddr=0, byteIdx=0.
- DATA:
  - byteReady=1.
  - Bytes are assembled little-endian: byteIdx 0 → bits[7:0], …, byteIdx 3 → bits[31:24].
  - On the transfer with byteIdx=3, mem[wordAddr] is written with the full word the same edge. Then wordAddr+1 and byteIdx=0.
  - byteIdx is 2-bit and wraps 3→0.
  - When the written word is the len-th (wordAddr==len-1) → RELEASE.
  - Maximum len is 4095, so wordAddr never wraps.
- RELEASE (exactly one cycle):
  - cpuRes=1, loadDone=1, cpuEnable=0, byteReady=0.
  - loaded set → IDLE.
  - cpuEnable=1 from the next cycle.

Boundary and ordering rules:
- loadStart outside IDLE is ignored.
- loadStart in the same cycle as res: res wins.
- byteValid while byteReady=0: no transfer; the byte is held by the source.
- Gaps (byteValid=0) in any loading state stall without state change.
- loading=1 in LEN_LO, LEN_HI, DATA and RELEASE.
- No read-during-write hazard: fetch returns NOP_WORD throughout loading.
- The write port is single; the store is inferred as RAM with a synchronous write and asynchronous read.

Test Plan:
- After res, loadStart, bytes 02,00, then 0F,00,00,00, 11,22,33,44 → mem[0]=0000000F, mem[1]=44332211. cpuRes/loadDone pulse exactly one cycle after the 8th data byte. cpuEnable=1 the cycle after. Fetch addr 1 → 44332211.
- Header 00,F0 (len=0) → RELEASE directly after the second byte. No writes. cpuEnable=1 two cycles after the header's last byte.
- During the load, insert byteValid=0 gaps of 3 cycles between bytes → same final memory and pulse timing relative to the last byte. byteReady stays 1 throughout.
- Assert res after the 5th data byte of a 2-word load → loading=0, cpuEnable=0, mem[0] written, fetch returns 0000000F. A fresh load then completes normally.
- Assert loadStart repeatedly mid-load → ignored; exactly len words are written.
- selInstruction=0 with loaded=1 → instruction=0000000F. selInstruction=1 before any completed load → 0000000F.

Source files
------------

// File: rtl/program_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_memory_loader
// Brief    : Instruction store for the CPU fetch port. A byte-stream loader
//            writes a program image while the CPU is held off, then releases
//            it with a one-cycle reset pulse.
// Revision : 1.0 - initial release
// ============================================================================
module program_memory_loader #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] NOP_WORD = 32'h0000000F
) (
    input  logic              clk,
    input  logic              res,
    input  logic [ADDR_W-1:0] instructionAddr,
    input  logic              selInstruction,
    output logic [31:0]       instruction,
    input  logic              loadStart,
    input  logic              byteValid,
    input  logic [7:0]        byteData,
    output logic              byteReady,
    output logic              loading,
    output logic              cpuEnable,
    output logic              cpuRes,
    output logic              loadDone
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (ADDR_W > 12) ? ADDR_W : 12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_DATA    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               loaded_q, loaded_d;
    logic [11:0]        len_q, len_d;
    logic [CNT_W-1:0]   word_addr_q, word_addr_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [23:0]        word_buf_q, word_buf_d;

    logic               w_xfer;
    logic               w_mem_we;
    logic [31:0]        w_mem_wdata;
    logic [31:0]        mem [0:DEPTH-1];

    assign byteReady   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign loading     = (state_q != S_IDLE);
    assign cpuEnable   = (state_q == S_IDLE) && loaded_q;
    assign cpuRes      = (state_q == S_RELEASE);
    assign loadDone    = (state_q == S_RELEASE);
    assign w_xfer      = byteValid && byteReady;
    assign w_mem_wdata = {byteData, word_buf_q};

    // Fetch is only served once a complete image is present and no load is active.
    assign instruction = (selInstruction && (state_q == S_IDLE) && loaded_q)
                         ? mem[instructionAddr] : NOP_WORD;

    always_comb begin
        state_d     = state_q;
        loaded_d    = loaded_q;
        len_d       = len_q;
        word_addr_d = word_addr_q;
        byte_idx_d  = byte_idx_q;
        word_buf_d  = word_buf_q;
        w_mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (loadStart) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    len_d[7:0] = byteData;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    len_d[11:8] = byteData[3:0];
                    word_addr_d = '0;
                    byte_idx_d  = 2'd0;
                    if ({byteData[3:0], len_q[7:0]} == 12'd0) begin
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = byteData;
                        2'd1: word_buf_d[15:8]  = byteData;
                        2'd2: word_buf_d[23:16] = byteData;
                        default: begin
                            w_mem_we    = 1'b1;
                            word_addr_d = word_addr_q + CNT_W'(1);
                            if (word_addr_q == (CNT_W'(len_q) - CNT_W'(1))) begin
                                state_d = S_RELEASE;
                            end
                        end
                    endcase
                end
            end
            S_RELEASE: begin
                loaded_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            loaded_q    <= 1'b0;
            len_q       <= '0;
            word_addr_q <= '0;
            byte_idx_q  <= '0;
            word_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            loaded_q    <= loaded_d;
            len_q       <= len_d;
            word_addr_q <= word_addr_d;
            byte_idx_q  <= byte_idx_d;
            word_buf_q  <= word_buf_d;
        end
    end

    // Store contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[word_addr_q[ADDR_W-1:0]] <= w_mem_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_memory_loader
// Brief    : Scoreboard bench for program_memory_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_memory_loader;

    localparam int          ADDR_W = 12;
    localparam logic [31:0] NOP    = 32'h0000000F;

    logic              clk = 1'b0;
    logic              res;
    logic [ADDR_W-1:0] instructionAddr;
    logic              selInstruction;
    logic [31:0]       instruction;
    logic              loadStart;
    logic              byteValid;
    logic [7:0]        byteData;
    logic              byteReady;
    logic              loading;
    logic              cpuEnable;
    logic              cpuRes;
    logic              loadDone;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] img [0:7];
    int          n_checks = 0;
    int          n_fail   = 0;

    program_memory_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
        .clk             (clk),
        .res             (res),
        .instructionAddr (instructionAddr),
        .selInstruction  (selInstruction),
        .instruction     (instruction),
        .loadStart       (loadStart),
        .byteValid       (byteValid),
        .byteData        (byteData),
        .byteReady       (byteReady),
        .loading         (loading),
        .cpuEnable       (cpuEnable),
        .cpuRes          (cpuRes),
        .loadDone        (loadDone)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit spam);
        for (int g = 0; g < gap; g++) begin
            byteValid = 1'b0;
            @(negedge clk);
            check_val("ready_in_gap", {31'd0, byteReady}, 32'd1);
        end
        byteValid = 1'b1;
        byteData  = b;
        loadStart = spam;
        check_val("ready_on_byte", {31'd0, byteReady}, 32'd1);
        @(negedge clk);
        byteValid = 1'b0;
        loadStart = 1'b0;
    endtask

    task automatic start_load();
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
        check_val("loading_after_start", {31'd0, loading}, 32'd1);
        check_val("cpu_en_after_start", {31'd0, cpuEnable}, 32'd0);
    endtask

    task automatic check_release();
        check_val("release_cpu_res", {31'd0, cpuRes}, 32'd1);
        check_val("release_done", {31'd0, loadDone}, 32'd1);
        check_val("release_cpu_en", {31'd0, cpuEnable}, 32'd0);
        check_val("release_ready", {31'd0, byteReady}, 32'd0);
        check_val("release_loading", {31'd0, loading}, 32'd1);
        @(negedge clk);
        check_val("post_cpu_res", {31'd0, cpuRes}, 32'd0);
        check_val("post_done", {31'd0, loadDone}, 32'd0);
        check_val("post_cpu_en", {31'd0, cpuEnable}, 32'd1);
        check_val("post_loading", {31'd0, loading}, 32'd0);
    endtask

    task automatic run_load(input int n, input int gap, input bit spam);
        logic [11:0] len;
        len = 12'(n);
        start_load();
        send_byte(len[7:0], gap, spam);
        send_byte({4'hA, len[11:8]}, gap, spam);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(img[i][8*b +: 8], gap, spam);
            end
            sb_q.push_back('{addr: ADDR_W'(i), data: img[i]});
        end
        check_release();
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            instructionAddr = e.addr;
            selInstruction  = 1'b1;
            #1;
            check_val($sformatf("fetch_%0d", e.addr), instruction, e.data);
        end
        selInstruction = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1; loadStart = 1'b0; byteValid = 1'b0; byteData = 8'h00;
        instructionAddr = '0; selInstruction = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check_val("rst_ready", {31'd0, byteReady}, 32'd0);
        check_val("rst_loading", {31'd0, loading}, 32'd0);
        check_val("rst_cpu_en", {31'd0, cpuEnable}, 32'd0);
        check_val("rst_cpu_res", {31'd0, cpuRes}, 32'd0);
        check_val("rst_done", {31'd0, loadDone}, 32'd0);
        selInstruction = 1'b1;
        #1;
        check_val("fetch_unloaded", instruction, NOP);
        selInstruction = 1'b0;
        @(negedge clk);

        // loadStart coincident with res is dropped
        res = 1'b1; loadStart = 1'b1;
        @(negedge clk);
        res = 1'b0; loadStart = 1'b0;
        @(negedge clk);
        check_val("res_beats_start", {31'd0, loading}, 32'd0);

        // Basic two-word load
        img[0] = 32'h0000000F; img[1] = 32'h44332211;
        run_load(2, 0, 1'b0);
        drain();
        instructionAddr = 12'd1; selInstruction = 1'b0;
        #1;
        check_val("sel_low_nop", instruction, NOP);
        @(negedge clk);

        // Zero-length header: straight to release, store untouched
        start_load();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hF0, 0, 1'b0);
        check_release();
        sb_q.push_back('{addr: ADDR_W'(1), data: 32'h44332211});
        drain();

        // Three-word load with 3-cycle gaps between bytes
        img[0] = 32'hAABBCCDD; img[1] = 32'h01020304; img[2] = 32'h55667788;
        run_load(3, 3, 1'b0);
        drain();

        // loadStart spammed mid-load; word 2 must keep its prior value
        img[0] = 32'hDEADBEEF; img[1] = 32'hCAFEF00D;
        run_load(2, 0, 1'b1);
        sb_q.push_back('{addr: ADDR_W'(2), data: 32'h55667788});
        drain();

        // Reset after 5th data byte of a two-word load
        start_load();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h0F, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        check_val("abort_loading", {31'd0, loading}, 32'd0);
        check_val("abort_cpu_en", {31'd0, cpuEnable}, 32'd0);
        check_val("abort_mem0", dut.mem[0], 32'h0000000F);
        instructionAddr = '0; selInstruction = 1'b1;
        #1;
        check_val("abort_fetch", instruction, NOP);
        selInstruction = 1'b0;
        @(negedge clk);

        img[0] = 32'h12345678; img[1] = 32'h9ABCDEF0;
        run_load(2, 0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
